// File: rtl/sd_block_reader.sv
// CMD17 single-block read sequencer driving the SPI byte engine and filling a 512-byte sector buffer.
// Define SD_BYTE_ADDR_EN for byte-addressed (SDSC) cards; default is block addressing (SDHC/SDXC).
module sd_block_reader #(
  parameter int R1_POLL    = 16,
  parameter int TOKEN_POLL = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout
);

  typedef enum logic [3:0] {
    S_RCS, S_IDLE, S_CSON, S_PRE, S_CMD, S_R1, S_TOK,
    S_DATA, S_CRC, S_CSOFF, S_POST, S_FIN
  } state_t;

  // Every engine op walks ISSUE -> SIG (strobe visible) -> GAP -> WAIT.
  typedef enum logic [1:0] {P_ISSUE, P_SIG, P_GAP, P_WAIT} phase_t;

  localparam logic [1:0] CMD_XCHG    = 2'd1;
  localparam logic [1:0] CMD_CS_LOW  = 2'd2;
  localparam logic [1:0] CMD_CS_HIGH = 2'd3;
  localparam logic [15:0] R1_LAST  = 16'(R1_POLL - 1);
  localparam logic [15:0] TOK_LAST = 16'(TOKEN_POLL - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] lba_q, lba_d;
  logic        error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        buf_we_q, buf_we_d;
  logic [8:0]  buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        sd_signal_q, sd_signal_d;
  logic [1:0]  sd_cmd_q, sd_cmd_d;
  logic [7:0]  sd_out_q, sd_out_d;

  logic        op_en;
  logic [1:0]  op_cmd;
  logic [7:0]  op_byte;
  logic [7:0]  cmd_byte;
  logic [31:0] cmd_arg;
  logic        issue_go;
  logic        op_done;

`ifdef SD_BYTE_ADDR_EN
  assign cmd_arg = {lba_q[22:0], 9'b0};
  wire unused_in = ^{sd_timeout, lba_q[31:23]};
`else
  assign cmd_arg = lba_q;
  wire unused_in = sd_timeout;
`endif

  always_comb begin
    cmd_byte = 8'hFF;
    case (cnt_q[2:0])
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = cmd_arg[31:24];
      3'd2:    cmd_byte = cmd_arg[23:16];
      3'd3:    cmd_byte = cmd_arg[15:8];
      3'd4:    cmd_byte = cmd_arg[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  end

  // Which engine operation the current state performs.
  always_comb begin
    op_en   = 1'b1;
    op_cmd  = CMD_XCHG;
    op_byte = 8'hFF;
    case (state_q)
      S_RCS, S_CSOFF: op_cmd = CMD_CS_HIGH;
      S_CSON:         op_cmd = CMD_CS_LOW;
      S_CMD:          op_byte = cmd_byte;
      S_IDLE, S_FIN:  op_en = 1'b0;
      default:        op_en = 1'b1;
    endcase
  end

  assign issue_go = op_en && (phase_q == P_ISSUE) && !sd_busy;
  assign op_done  = op_en && (phase_q == P_WAIT) && !sd_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RCS;
      phase_q     <= P_ISSUE;
      cnt_q       <= '0;
      lba_q       <= '0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      sd_signal_q <= 1'b0;
      sd_cmd_q    <= '0;
      sd_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      lba_q       <= lba_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      sd_signal_q <= sd_signal_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_out_q    <= sd_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    lba_d      = lba_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    case (phase_q)
      P_ISSUE: if (issue_go) phase_d = P_SIG;
      P_SIG:   phase_d = P_GAP;
      P_GAP:   phase_d = P_WAIT;
      default: if (!sd_busy) phase_d = P_ISSUE;
    endcase

    case (state_q)
      S_RCS:  if (op_done) state_d = S_IDLE;
      S_IDLE: begin
        if (rd_req) begin
          lba_d      = lba;
          error_d    = 1'b0;
          err_code_d = 3'd0;
          state_d    = S_CSON;
        end
      end
      S_CSON: if (op_done) state_d = S_PRE;
      S_PRE: begin
        if (op_done) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (op_done) begin
          if (cnt_q[2:0] == 3'd5) begin
            state_d = S_R1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_R1: begin
        if (op_done) begin
          if (!sd_din[7]) begin
            if (sd_din == 8'h00) begin
              state_d = S_TOK;
              cnt_d   = '0;
            end else begin
              error_d    = 1'b1;
              err_code_d = 3'd1;
              state_d    = S_CSOFF;
            end
          end else if (cnt_q == R1_LAST) begin
            error_d    = 1'b1;
            err_code_d = 3'd2;
            state_d    = S_CSOFF;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_TOK: begin
        if (op_done) begin
          if (sd_din == 8'hFE) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else if (sd_din != 8'hFF) begin
            error_d    = 1'b1;
            err_code_d = 3'd3;
            state_d    = S_CSOFF;
          end else if (cnt_q == TOK_LAST) begin
            error_d    = 1'b1;
            err_code_d = 3'd4;
            state_d    = S_CSOFF;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DATA: begin
        if (op_done) begin
          if (cnt_q[8:0] == 9'd511) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_CRC: begin
        if (op_done) begin
          if (cnt_q[0]) state_d = S_CSOFF;
          else          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_CSOFF: if (op_done) state_d = S_POST;
      S_POST:  if (op_done) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs; done and busy drop land together in the FIN cycle.
  always_comb begin
    sd_signal_d = 1'b0;
    sd_cmd_d    = sd_cmd_q;
    sd_out_d    = sd_out_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    if (issue_go) begin
      sd_signal_d = 1'b1;
      sd_cmd_d    = op_cmd;
      sd_out_d    = op_byte;
    end
    if (state_q == S_DATA && op_done) begin
      buf_we_d   = 1'b1;
      buf_addr_d = cnt_q[8:0];
      buf_data_d = sd_din;
    end
    if (state_q == S_RCS && op_done) busy_d = 1'b0;
    if (state_q == S_IDLE && rd_req) busy_d = 1'b1;
    if (state_q == S_POST && op_done) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_data  = buf_data_q;
  assign sd_signal = sd_signal_q;
  assign sd_cmd    = sd_cmd_q;
  assign sd_out    = sd_out_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader with a behavioural SPI engine and SD card response model.
module tb_sd_block_reader;

  localparam int TP  = 40;
  localparam int BIG = 1000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] lba = '0;
  logic        busy, done, error, buf_we, sd_signal;
  logic [2:0]  err_code;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data, sd_out;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_din = 8'hFF;
  logic        sd_busy = 1'b0;
  logic        sd_timeout = 1'b0;

  sd_block_reader #(.R1_POLL(16), .TOKEN_POLL(TP)) dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .lba(lba),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout)
  );

  always #20 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Card behaviour knobs, indexed by exchange number after the CMD17 frame.
  int         r1_wait, tok_wait;
  logic [7:0] r1_val, tok_val;

  function automatic logic [7:0] card_resp(input int k);
    int j, d;
    if (k < 0) return 8'hFF;
    if (k < r1_wait) return 8'hFF;
    if (k == r1_wait) return r1_val;
    if (r1_val != 8'h00) return 8'hFF;
    j = k - r1_wait - 1;
    if (j < tok_wait) return 8'hFF;
    if (j == tok_wait) return tok_val;
    if (tok_val != 8'hFE) return 8'hFF;
    d = j - tok_wait - 1;
    if (d < 512) return d[7:0];
    return 8'hFF;
  endfunction

  // Engine model: busy rises one cycle after the cycle following the strobe.
  int         nx = 0, post_exch = 0, cs2_cnt = 0, cs3_cnt = 0;
  bit         cs_low = 1'b0;
  logic [7:0] txlog [0:6];
  logic       pend = 1'b0;
  int         bcnt = 0;
  logic [7:0] resp_q = 8'hFF;

  always @(posedge clock) begin
    pend <= sd_signal;
    if (sd_signal) begin
      case (sd_cmd)
        2'd2: begin cs_low = 1'b1; nx = 0; cs2_cnt++; resp_q <= 8'hFF; end
        2'd3: begin cs_low = 1'b0; cs3_cnt++; resp_q <= 8'hFF; end
        2'd1: begin
          if (cs_low) begin
            if (nx < 7) txlog[nx] = sd_out;
            resp_q <= card_resp(nx - 7);
            nx++;
          end else begin
            post_exch++;
            resp_q <= 8'hFF;
          end
        end
        default: resp_q <= 8'hFF;
      endcase
    end
    if (pend) begin
      sd_busy <= 1'b1;
      bcnt    <= 2;
    end else if (sd_busy) begin
      if (bcnt == 0) begin
        sd_busy <= 1'b0;
        sd_din  <= resp_q;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // Sector-buffer monitor: every write must land at the next index with the card's byte.
  int   we_idx = 0;
  int   done_cnt = 0;
  int   consec = 0;
  logic prev_sig = 1'b0;
  always @(negedge clock) begin
    if (buf_we) begin
      chk("buf_write", {46'd0, buf_addr, buf_data}, {46'd0, 9'(we_idx), 8'(we_idx)});
      we_idx++;
    end
    if (done) done_cnt++;
    if (sd_signal && prev_sig) consec++;
    prev_sig = sd_signal;
  end

  typedef struct {
    logic [31:0] lba;
    int          r1_wait;
    logic [7:0]  r1_val;
    int          tok_wait;
    logic [7:0]  tok_val;
    logic        exp_err;
    logic [2:0]  exp_code;
    int          exp_we;
    int          exp_resp;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [47:0] exp_frame(input logic [31:0] l);
    logic [31:0] a;
`ifdef SD_BYTE_ADDR_EN
    a = {l[22:0], 9'b0};
`else
    a = l;
`endif
    return {8'h51, a, 8'hFF};
  endfunction

  function automatic logic all_ok_dummy(input int x);
    return x != 0;
  endfunction

  task automatic wait_done(input string tag, output bit ok);
    int cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    ok = done;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_timeout: got no done expected done within 20000 cycles", tag);
    end
  endtask

  // fin_mode 0: plain; 1: rd_req only in FIN cycle (ignored); 2: rd_req in FIN and next cycle (accepted).
  task automatic run_row(input int r, input int fin_mode);
    vec_t v;
    int   c3_0, p0;
    bit   ok;
    v = tbl[r];
    r1_wait = v.r1_wait; r1_val = v.r1_val;
    tok_wait = v.tok_wait; tok_val = v.tok_val;
    c3_0 = cs3_cnt; p0 = post_exch;
    @(negedge clock);
    we_idx = 0;
    lba = v.lba;
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
    wait_done($sformatf("row%0d", r), ok);
    if (!ok) return;
    $display("row %0d: lba=%08h err=%0d code=%0d writes=%0d resp_exch=%0d", r, v.lba, error, err_code, we_idx, nx - 7);
    chk($sformatf("row%0d_error", r), 64'(error), 64'(v.exp_err));
    chk($sformatf("row%0d_err_code", r), 64'(err_code), 64'(v.exp_code));
    chk($sformatf("row%0d_buf_writes", r), 64'(we_idx), 64'(v.exp_we));
    chk($sformatf("row%0d_resp_exchanges", r), 64'(nx - 7), 64'(v.exp_resp));
    chk($sformatf("row%0d_cmd_frame", r),
        64'({txlog[1], txlog[2], txlog[3], txlog[4], txlog[5], txlog[6]}), 64'(exp_frame(v.lba)));
    chk($sformatf("row%0d_cs_released", r), 64'(cs_low), 64'd0);
    chk($sformatf("row%0d_cs_high_ops", r), 64'(cs3_cnt - c3_0), 64'd1);
    chk($sformatf("row%0d_post_exch", r), 64'(post_exch - p0), 64'd1);
    chk($sformatf("row%0d_busy_at_done", r), 64'(busy), 64'd0);
    if (fin_mode != 0) rd_req = 1'b1;
    @(negedge clock);
    chk($sformatf("row%0d_done_width", r), 64'(done), 64'd0);
    if (fin_mode == 1) begin
      rd_req = 1'b0;
      repeat (3) @(negedge clock);
      chk("fin_req_ignored", 64'(busy), 64'd0);
    end else if (fin_mode == 2) begin
      we_idx = 0;
      @(negedge clock);
      rd_req = 1'b0;
      chk("post_fin_req_accepted", 64'(busy), 64'd1);
      wait_done("post_fin", ok);
      if (ok) begin
        $display("post-FIN read: err=%0d writes=%0d", error, we_idx);
        chk("post_fin_error", 64'(error), 64'd0);
        chk("post_fin_writes", 64'(we_idx), 64'd512);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int  cyc;
    int  dn0;
    bit  ok;

    tbl[0] = '{32'h0000_0005, 2,   8'h00, 3,   8'hFE, 1'b0, 3'd0, 512, 521};
    tbl[1] = '{32'h0000_0005, 2,   8'h04, 0,   8'hFE, 1'b1, 3'd1, 0,   3};
    tbl[2] = '{32'h0000_0005, BIG, 8'h00, 0,   8'hFE, 1'b1, 3'd2, 0,   16};
    tbl[3] = '{32'h0000_0005, 0,   8'h00, BIG, 8'hFE, 1'b1, 3'd4, 0,   1 + TP};
    tbl[4] = '{32'h0000_0005, 0,   8'h00, 1,   8'h08, 1'b1, 3'd3, 0,   3};
    tbl[5] = '{32'h1234_5678, 0,   8'h00, 0,   8'hFE, 1'b0, 3'd0, 512, 516};
    r1_wait = 0; r1_val = 8'h00; tok_wait = 0; tok_val = 8'hFE;

    // Reset state, then the CS-high release after reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("reset: busy=%0d done=%0d sd_signal=%0d sd_cmd=%0d", busy, done, sd_signal, sd_cmd);
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_outputs", {42'd0, done, error, err_code, buf_we, buf_addr, buf_data},
        64'd0);
    chk("reset_engine_outputs", {53'd0, sd_signal, sd_cmd, sd_out}, 64'd0);
    reset = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin @(negedge clock); cyc++; end
    chk("rcs_busy_released", 64'(busy), 64'd0);
    chk("rcs_cs_high_once", 64'(cs3_cnt), 64'd1);
    chk("rcs_last_cmd", 64'(sd_cmd), 64'd3);

    run_row(0, 1);
    for (int r = 1; r < 5; r++) run_row(r, 0);
    run_row(5, 2);

    // Reset asserted mid-data: abort, release CS, no done pulse, then a clean read.
    r1_wait = tbl[0].r1_wait; r1_val = tbl[0].r1_val;
    tok_wait = tbl[0].tok_wait; tok_val = tbl[0].tok_val;
    dn0 = done_cnt;
    @(negedge clock);
    we_idx = 0;
    lba = 32'h0000_0005;
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
    cyc = 0;
    while (!(buf_we && buf_addr == 9'd100) && cyc < 20000) begin @(negedge clock); cyc++; end
    chk("reached_byte_100", 64'(buf_we && buf_addr == 9'd100), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    $display("mid-read reset: busy=%0d buf_we=%0d buf_addr=%0d sd_signal=%0d", busy, buf_we, buf_addr, sd_signal);
    chk("midreset_busy", 64'(busy), 64'd1);
    chk("midreset_outputs", {42'd0, done, error, err_code, buf_we, buf_addr, buf_data}, 64'd0);
    chk("midreset_engine_outputs", {53'd0, sd_signal, sd_cmd, sd_out}, 64'd0);
    reset = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin @(negedge clock); cyc++; end
    chk("midreset_busy_released", 64'(busy), 64'd0);
    chk("midreset_cs_released", 64'(cs_low), 64'd0);
    chk("midreset_last_cmd", 64'(sd_cmd), 64'd3);
    repeat (5) @(negedge clock);
    chk("midreset_no_done", 64'(done_cnt - dn0), 64'd0);

    run_row(0, 0);

    chk("strobe_never_back_to_back", 64'(consec), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_block_reader.md
Name: sd_block_reader

Overview:
- Sector-read sequencer that sits directly upstream of the SPI byte engine (module `sd`).
- Drives the engine's command interface to read one 512-byte block with CMD17.
- Streams the data bytes into a sector buffer through a write port.
- Card initialisation (CMD0/CMD8/ACMD41) is out of scope; software completes it before the first request.

Parameters:
R1_POLL, 16, max 0xFF exchanges waiting for R1 (bit7=0)
TOKEN_POLL, 50000, max 0xFF exchanges waiting for data token 0xFE (16-bit counter)

Ports:
clock  in  1  system clock, 25 MHz
reset  in  1  synchronous, active-high
rd_req  in  1  start a read; sampled only when busy=0
lba  in  32  block number, latched on accepted rd_req
busy  out  1  =1 from accept until the done pulse
done  out  1  one-cycle pulse at end of operation
error  out  1  valid with done, held until next accept
err_code  out  3  0 ok, 1 R1 nonzero, 2 R1 timeout, 3 data error token, 4 token timeout
buf_we  out  1  one-cycle write strobe per data byte
buf_addr  out  9  byte index 0..511
buf_data  out  8  data byte
sd_signal  out  1  one-cycle command strobe to the engine
sd_cmd  out  2  0 init-80-clocks (never used), 1 byte exchange, 2 CS low, 3 CS high
sd_out  out  8  byte to transmit
sd_din  in  8  byte received by the last exchange
sd_busy  in  1  engine busy, registered
sd_timeout  in  1  unused, reserved

Behaviour:

Engine handshake (ISSUE/GAP/WAIT, every engine op):
- ISSUE: only when sd_busy=0, drive sd_signal=1 with sd_cmd/sd_out for exactly one cycle.
- GAP: one cycle, ignore sd_busy (engine asserts busy one cycle late).
- WAIT: wait for sd_busy=0; sd_din is then valid.
- sd_signal is never high on two consecutive cycles.

Reset:
- busy=1, done=0, error=0, err_code=0, buf_we=0, buf_addr=0, buf_data=0, sd_signal=0, sd_cmd=0, sd_out=0.
- State after reset is RCS: issue cmd 3 (CS high, after sd_busy=0), then IDLE with busy=0.
- Reset mid-operation aborts the transfer. No done pulse; the buffer holds partial data.

States (each engine op uses the handshake above):
- IDLE: rd_req=1 → latch lba; busy=1; error=0; err_code=0; → CSON. rd_req while busy is ignored.
- CSON: cmd 2 → PRE.
- PRE: exchange 0xFF → CMD.
- CMD: exchange 6 bytes, in order:
  - 0x51
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
  - 0xFF
  - arg = lba (see optional feature).
  - → R1.
- R1: exchange 0xFF, up to R1_POLL times.
  - First sd_din with bit7=0: value 0x00 → TOK; any other value → err 1.
  - Poll count exhausted → err 2.
- TOK: exchange 0xFF, up to TOKEN_POLL times.
  - 0xFE → DATA.
  - 0xFF → keep polling.
  - Any other value → err 3.
  - Poll count exhausted → err 4.
- DATA: 512 exchanges of 0xFF.
  - After each WAIT: buf_we=1 for one cycle, buf_data=sd_din, buf_addr=index.
  - Index counts 0..511 and never wraps within a block.
  - → CRC.
- CRC: 2 exchanges of 0xFF, received bytes discarded → CSOFF.
- CSOFF: cmd 3 → POST.
- POST: exchange 0xFF (8 trailing clocks) → FIN.
- FIN: done=1 for one cycle; busy=0 in the same cycle; → IDLE.
- Error path: latch err_code, error=1, go straight to CSOFF. The data phase is skipped and CS is always released.

Timing and counters:
- A request with rd_req=1 in the FIN cycle is ignored; a request on the next cycle is accepted.
- Poll counters reset on entry to R1 and to TOK.
- Latency with no polling waits: 1 CS op + 1 + 6 + 1 + 1 + 512 + 2 + 1 CS op + 1 exchanges.

Optional Feature:
Macro: SD_BYTE_ADDR_EN
- Defined: the CMD17 argument is {lba[22:0], 9'b0}, byte addressing for SDSC cards.
- Undefined: the CMD17 argument is lba unchanged, block addressing for SDHC/SDXC cards.
- Nothing else changes.

Test Plan:
- Card model:
  - R1=0x00 after 2 polls, token 0xFE after 3 polls, data byte i = i[7:0], lba=0x00000005.
  - Required: CMD bytes 51 00 00 00 05 FF.
  - Required: 512 buf_we pulses with addr 0..511 and data 00..FF repeating.
  - Required: then one done pulse with error=0, and CS released before done.
- With SD_BYTE_ADDR_EN defined, lba=0x00000005 → CMD bytes 51 00 00 0A 00 FF.
- R1=0x04 → done with error=1, err_code=1, zero buf_we pulses, cmd 3 issued before done.
- Card returns 0xFF forever:
  - Exactly 16 R1 exchanges, then err_code=2.
  - Separately with R1=0x00: TOKEN_POLL exchanges, then err_code=4.
- Token byte 0x08 → err_code=3, no buf_we, CS released.
- Assert reset at data byte 100 → outputs take reset values next cycle, cmd 3 issued once sd_busy=0, busy=0 afterwards, no done pulse. A following rd_req completes a normal read.
